// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle wide adder built around a single 4-bit ripple-carry stage.
//   Operands are captured on an accepted start and consumed one nibble per
//   clock, least significant nibble first. The carry between nibbles lives in
//   carry_reg. When the top nibble has been added, the full sum and the final
//   carry-out are loaded into the output registers.
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous, active-high reset (drops any operation in flight)
//   start  begin an add; only looked at while idle
//   a, b   W-bit operands, W = 4*NIBBLES, captured with start
//   cin    carry into nibble 0, captured with start
//   busy   high while nibbles are being added
//   done   one-cycle pulse; sum/cout hold the new result
//   sum    registered W-bit result (holds the previous result until the next one completes)
//   cout   registered carry-out of the most significant nibble
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [W-1:0]    a_reg, b_reg;
    logic [W-1:0]    partial_reg, partial_next;
    logic [W-1:0]    sum_reg;
    logic            carry_reg, cout_reg;
    logic [IW-1:0]   idx_reg;

    logic [3:0]      a_nib, b_nib, nib_sum;
    logic [4:0]      chain;
    logic            last_nib;

    assign last_nib = (idx_reg == LAST_IDX);

    // Select the current nibble pair from the captured operands.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_reg == IW'(i)) begin
                a_nib = a_reg[4*i +: 4];
                b_nib = b_reg[4*i +: 4];
            end
        end
    end

    // 4-bit ripple chain; chain[0] is the carry held from the previous nibble.
    assign chain[0] = carry_reg;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ripple
            assign nib_sum[gi]   = a_nib[gi] ^ b_nib[gi] ^ chain[gi];
            assign chain[gi+1]   = (a_nib[gi] & b_nib[gi]) |
                                   (chain[gi] & (a_nib[gi] ^ b_nib[gi]));
        end
    endgenerate

    // Partial result with the current nibble sum merged in. On the last
    // nibble this is the complete sum, so it can be loaded straight into
    // sum_reg on the same edge.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_partial
            assign partial_next[4*gi +: 4] = (idx_reg == IW'(gi)) ? nib_sum
                                                                  : partial_reg[4*gi +: 4];
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ADD;
            ADD:     if (last_nib) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg       <= '0;
            b_reg       <= '0;
            carry_reg   <= 1'b0;
            idx_reg     <= '0;
            partial_reg <= '0;
            sum_reg     <= '0;
            cout_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx_reg   <= '0;
                    end
                end
                ADD: begin
                    partial_reg <= partial_next;
                    carry_reg   <= chain[4];
                    if (last_nib) begin
                        sum_reg  <= partial_next;
                        cout_reg <= chain[4];
                    end else begin
                        idx_reg <= idx_reg + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg == ADD);
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    logic         start1, cin1;
    logic [3:0]   a1, b1, sum1;
    logic         busy1, done1, cout1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: timestamp of the accepted start plus the arithmetic
    // result a+b+cin. Output timing follows from the accept edge T:
    // busy after edges T..T+N-1, done after edge T+N, next accept at T+N+2.
    logic         m_active = 1'b0;
    int           m_t      = 0;
    logic [W:0]   m_res    = '0;
    logic         exp_busy = 1'b0, exp_done = 1'b0, exp_cout = 1'b0;
    logic [W-1:0] exp_sum  = '0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_active = 1'b0;
            exp_sum  = '0;
            exp_cout = 1'b0;
        end else begin
            if (start && (!m_active || cyc >= m_t + N + 2)) begin
                m_active = 1'b1;
                m_t      = cyc;
                m_res    = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            end
            if (m_active && cyc == m_t + N) {exp_cout, exp_sum} = m_res;
        end
        exp_busy = m_active && (cyc >= m_t) && (cyc < m_t + N);
        exp_done = m_active && (cyc == m_t + N);
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("model_busy", busy, exp_busy);
            chk("model_done", done, exp_done);
            chk("model_sum",  sum,  exp_sum);
            chk("model_cout", cout, exp_cout);
            if (done) done_cnt++;
        end
    end

    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                      output int lat);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
    endtask

    initial begin
        int lat, dc0, d1, d2;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_sum",  sum,  0);
        chk("reset_cout", cout, 0);
        chk("reset_sum1", sum1, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic add with latency check
        op(16'h1234, 16'h4321, 1'b0, lat);
        chk("basic_latency", lat, N);
        chk("basic_sum", sum, 16'h5555);
        chk("basic_cout", cout, 0);
        @(negedge clk);

        // Full carry ripple
        op(16'hFFFF, 16'h0001, 1'b0, lat);
        chk("ripple1_sum", sum, 16'h0000);
        chk("ripple1_cout", cout, 1);
        @(negedge clk);
        op(16'hFFFF, 16'hFFFF, 1'b1, lat);
        chk("ripple2_sum", sum, 16'hFFFF);
        chk("ripple2_cout", cout, 1);
        @(negedge clk);

        // start ignored while busy
        dc0 = done_cnt;
        a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin @(negedge clk); lat++; end
        chk("ignore_sum", sum, 16'h0002);
        repeat (10) @(negedge clk);
        chk("ignore_done_count", done_cnt - dc0, 1);
        chk("ignore_idle", busy, 0);

        // Back-to-back with start held high
        d1 = -1; d2 = -1;
        a = 16'h0010; b = 16'h0020; cin = 1'b0; start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 0) begin a = 16'h1000; b = 16'h2000; end
            if (i == 6) start = 1'b0;
            if (done) begin
                if (d1 < 0) d1 = i; else d2 = i;
            end
            if (i == 9)  chk("b2b_hold_sum", sum, 16'h0030);
            if (i == 10) chk("b2b_second_sum", sum, 16'h3000);
        end
        chk("b2b_first_done", d1, 4);
        chk("b2b_done_gap", d2 - d1, 6);

        // Reset in the middle of an operation
        a = 16'h8888; b = 16'h8888; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_sum",  sum,  0);
        chk("midrst_cout", cout, 0);
        rst = 1'b0;
        dc0 = done_cnt;
        repeat (8) @(negedge clk);
        chk("midrst_no_done", done_cnt - dc0, 0);
        op(16'h0003, 16'h0004, 1'b0, lat);
        chk("post_rst_sum", sum, 16'h0007);
        chk("post_rst_cout", cout, 0);
        @(negedge clk);

        // Single-nibble instance
        a1 = 4'hF; b1 = 4'h1; cin1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("n1_busy", busy1, 1);
        chk("n1_done_early", done1, 0);
        @(negedge clk);
        chk("n1_done", done1, 1);
        chk("n1_sum", sum1, 4'h1);
        chk("n1_cout", cout1, 1);
        @(negedge clk);
        chk("n1_done_pulse", done1, 0);
        chk("n1_idle", busy1, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
